// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding a single UART serializer. One requester is
// granted per frame; the arbiter then supervises the serializer handshake
// (start seen via tx_ready falling, end via tx_ready rising again).
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned START_TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  input  logic                 tx_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  output logic                 busy,
  output logic [1:0]           last_grant,
  output logic                 err,
  output logic [15:0]          frame_count
);

  localparam int unsigned TW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [1:0]           last_grant_q, last_grant_d;
  logic                 err_q, err_d;
  logic [15:0]          frame_count_q, frame_count_d;
  logic [TW-1:0]        timeout_q, timeout_d;

  logic                 win_found;
  logic [1:0]           win_idx;
  logic [1:0]           probe;
  logic [7:0]           win_byte;

  // Round-robin search starting just after the previous winner
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    probe     = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      probe = last_grant_q + 2'(k);
      if (!win_found && req[probe]) begin
        win_found = 1'b1;
        win_idx   = probe;
      end
    end
    win_byte = req_data[{win_idx, 3'b000} +: 8];
  end

  // Next-state and register-update logic
  always_comb begin
    state_d       = state_q;
    ack_d         = '0;
    tx_data_d     = tx_data_q;
    last_grant_d  = last_grant_q;
    err_d         = err_q;
    frame_count_d = frame_count_q;
    timeout_d     = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (win_found && tx_ready) begin
          state_d         = S_LAUNCH;
          tx_data_d       = win_byte;
          ack_d[win_idx]  = 1'b1;
          last_grant_d    = win_idx;
        end
      end
      S_LAUNCH: begin
        state_d   = S_WAIT_BUSY;
        timeout_d = '0;
      end
      S_WAIT_BUSY: begin
        if (!tx_ready) begin
          state_d = S_WAIT_DONE;
        end else begin
          timeout_d = timeout_q + TW'(1);
          if (timeout_q == TW'(START_TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (tx_ready) begin
          state_d       = S_IDLE;
          frame_count_d = frame_count_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ack_q         <= '0;
      tx_data_q     <= '0;
      last_grant_q  <= 2'd3;
      err_q         <= 1'b0;
      frame_count_q <= '0;
      timeout_q     <= '0;
    end else begin
      state_q       <= state_d;
      ack_q         <= ack_d;
      tx_data_q     <= tx_data_d;
      last_grant_q  <= last_grant_d;
      err_q         <= err_d;
      frame_count_q <= frame_count_d;
      timeout_q     <= timeout_d;
    end
  end

  // Strobes are masked while reset is asserted so an aborted frame emits nothing
  assign ack         = ack_q & {NUM_REQ{~rst}};
  assign tx_start    = (state_q == S_LAUNCH) & ~rst;
  assign tx_data     = tx_data_q;
  assign busy        = (state_q != S_IDLE);
  assign last_grant  = last_grant_q;
  assign err         = err_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed vector table, hand-written
// corner sequences, and a randomized phase against a round-robin reference.
module tb_uart_tx_arbiter;

  localparam int BIT_CYCLES = 16;
  localparam int FRAME_LEN  = 10 * BIT_CYCLES;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        tx_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic [1:0]  last_grant;
  logic        err;
  logic [15:0] frame_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Serializer model: 0 = normal UART, 1 = never starts, 2 = bench-driven
  logic [1:0] ser_mode  = 2'd0;
  logic       man_ready = 1'b1;
  logic [8:0] ser_cnt   = '0;

  uart_tx_arbiter #(.NUM_REQ(4), .START_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data), .busy(busy),
    .last_grant(last_grant), .err(err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Serializer frame timer: busy for one 10-bit frame after each start
  always @(posedge clk) begin
    if (ser_cnt == 0) begin
      if (tx_start && ser_mode == 2'd0) ser_cnt <= 9'(FRAME_LEN);
    end else begin
      ser_cnt <= ser_cnt - 9'd1;
    end
  end

  assign tx_ready = (ser_mode == 2'd2) ? man_ready :
                    (ser_mode == 2'd1) ? 1'b1 : (ser_cnt == 0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int rr(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] d, input int i);
    return d[8*i +: 8];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ack(input int bound, output logic [3:0] a, output int n);
    a = '0;
    n = 0;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (ack != 0) begin
        a = ack;
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int bound, output int cyc, output logic stable, output int starts);
    logic [7:0] d0;
    d0 = tx_data;
    cyc = 0;
    stable = 1'b1;
    starts = 0;
    while (busy && cyc < bound) begin
      @(negedge clk);
      cyc++;
      if (busy && tx_data !== d0) stable = 1'b0;
      if (tx_start) starts++;
    end
  endtask

  // Starts at a negedge; issues the request and follows the frame to IDLE
  task automatic run_frame(input logic [3:0] r, input logic [31:0] data, input bit hold,
                           output logic [3:0] a, output int n, output logic [7:0] d,
                           output logic [1:0] lg, output logic st, output int cyc,
                           output logic stable, output int starts);
    req = r;
    req_data = data;
    wait_ack(400, a, n);
    d  = tx_data;
    lg = last_grant;
    st = tx_start;
    if (!hold) req = '0;
    wait_idle(400, cyc, stable, starts);
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] exp_ack;
    logic [1:0] exp_lg;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [3:0] a;
    logic [7:0] d;
    logic [1:0] lg;
    logic       st, stable, flag;
    int         n, cyc, starts, w, m_last, grants, fc0;
    logic [15:0] fc_before;

    vecs[0] = '{4'b1111, 4'b0001, 2'd0, 8'hA1};
    vecs[1] = '{4'b1111, 4'b0010, 2'd1, 8'hB2};
    vecs[2] = '{4'b1010, 4'b1000, 2'd3, 8'hD4};
    vecs[3] = '{4'b0110, 4'b0010, 2'd1, 8'hB2};
    vecs[4] = '{4'b0001, 4'b0001, 2'd0, 8'hA1};
    vecs[5] = '{4'b0001, 4'b0001, 2'd0, 8'hA1};
    vecs[6] = '{4'b1001, 4'b1000, 2'd3, 8'hD4};
    vecs[7] = '{4'b0100, 4'b0100, 2'd2, 8'hC3};

    req = '0;
    req_data = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_ack", 32'(ack), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_frame_count", 32'(frame_count), 0);
    chk("rst_last_grant", 32'(last_grant), 3);
    @(negedge clk);
    chk("post_rst_tx_start", 32'(tx_start), 0);
    chk("post_rst_busy", 32'(busy), 0);

    // Single frame through a UART-paced serializer
    run_frame(4'b0001, 32'h0000_0046, 1'b0, a, n, d, lg, st, cyc, stable, starts);
    chk("f1_ack", 32'(a), 32'h1);
    chk("f1_latency", 32'(n), 1);
    chk("f1_tx_start", 32'(st), 1);
    chk("f1_tx_data", 32'(d), 32'h46);
    chk("f1_data_stable", 32'(stable), 1);
    chk("f1_single_start", 32'(starts), 0);
    chk("f1_frame_len_ok", 32'(cyc > FRAME_LEN), 1);
    chk("f1_idle", 32'(busy), 0);
    chk("f1_frame_count", 32'(frame_count), 1);

    // Arbitration vector table from a fresh reset
    do_reset();
    foreach (vecs[i]) begin
      run_frame(vecs[i].req, 32'hD4C3_B2A1, 1'b0, a, n, d, lg, st, cyc, stable, starts);
      chk($sformatf("vec%0d_ack", i), 32'(a), 32'(vecs[i].exp_ack));
      chk($sformatf("vec%0d_last_grant", i), 32'(lg), 32'(vecs[i].exp_lg));
      chk($sformatf("vec%0d_tx_data", i), 32'(d), 32'(vecs[i].exp_byte));
      chk($sformatf("vec%0d_frame_count", i), 32'(frame_count), 32'(i + 1));
    end

    // All requesters held: rotation 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_frame(4'b1111, 32'h4433_2211, 1'b1, a, n, d, lg, st, cyc, stable, starts);
      chk($sformatf("rot%0d_ack", i), 32'(a), 32'(4'b0001 << (i % 4)));
      chk($sformatf("rot%0d_last_grant", i), 32'(lg), 32'(i % 4));
      if (i > 0) chk($sformatf("rot%0d_gap", i), 32'(n), 1);
    end
    req = '0;
    @(negedge clk);

    // Request while serializer not ready: no grant until tx_ready rises
    ser_mode = 2'd2;
    man_ready = 1'b0;
    req = 4'b0100;
    req_data = 32'h0055_0000;
    flag = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ack != 0 || busy) flag = 1'b1;
    end
    chk("notready_no_grant", 32'(flag), 0);
    man_ready = 1'b1;
    wait_ack(5, a, n);
    ser_mode = 2'd0;
    chk("notready_ack", 32'(a), 32'h4);
    chk("notready_latency", 32'(n), 1);
    req = '0;
    wait_idle(400, cyc, stable, starts);

    // Serializer never starts: timeout after 8 WAIT_BUSY cycles
    chk("to_err_before", 32'(err), 0);
    fc_before = frame_count;
    ser_mode = 2'd1;
    run_frame(4'b0001, 32'h0000_0077, 1'b0, a, n, d, lg, st, cyc, stable, starts);
    chk("to_ack", 32'(a), 32'h1);
    chk("to_cycles", 32'(cyc), 9);
    chk("to_err", 32'(err), 1);
    chk("to_idle", 32'(busy), 0);
    chk("to_frame_count", 32'(frame_count), 32'(fc_before));
    ser_mode = 2'd0;
    @(negedge clk);

    // Reset mid-frame during WAIT_DONE
    req = 4'b0010;
    req_data = 32'h0000_9900;
    wait_ack(20, a, n);
    req = '0;
    for (int i = 0; i < 20 && tx_ready; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("midrst_in_frame", 32'(busy && !tx_ready), 1);
    rst = 1'b1;
    #1;
    chk("midrst_no_start", 32'(tx_start), 0);
    chk("midrst_no_ack", 32'(ack), 0);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_idle", 32'(busy), 0);
    chk("midrst_err", 32'(err), 0);
    chk("midrst_frame_count", 32'(frame_count), 0);
    chk("midrst_last_grant", 32'(last_grant), 3);
    req = 4'b1111;
    req_data = 32'h0000_00E1;
    wait_ack(400, a, n);
    chk("midrst_next_grant", 32'(a), 32'h1);
    req = '0;
    wait_idle(400, cyc, stable, starts);
    chk("midrst_frame_done", 32'(frame_count), 1);

    // Randomized traffic against the round-robin reference
    m_last = 0;
    grants = 0;
    fc0 = int'(frame_count);
    flag = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (tx_start != (ack != 0)) flag = 1'b1;
      if (ack != 0) begin
        w = rr(req, m_last);
        chk("rand_ack", 32'(ack), (w < 0) ? 32'hFF : 32'(4'b0001 << w));
        chk("rand_tx_data", 32'(tx_data), (w < 0) ? 32'h1FF : 32'(byte_of(req_data, w)));
        chk("rand_last_grant", 32'(last_grant), 32'(w));
        if (w >= 0) m_last = w;
        grants++;
        req = req & ~ack;
      end
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && $urandom_range(0, 5) == 0) begin
          req_data[8*i +: 8] = 8'($urandom);
          req[i] = 1'b1;
        end
      end
    end
    for (int c = 0; c < 4000 && (req != 0 || busy); c++) begin
      @(negedge clk);
      if (tx_start != (ack != 0)) flag = 1'b1;
      if (ack != 0) begin
        w = rr(req, m_last);
        chk("drain_ack", 32'(ack), (w < 0) ? 32'hFF : 32'(4'b0001 << w));
        if (w >= 0) m_last = w;
        grants++;
        req = req & ~ack;
      end
    end
    chk("rand_drained", 32'(req != 0 || busy), 0);
    chk("rand_start_ack_align", 32'(flag), 0);
    chk("rand_frame_count", 32'(frame_count), 32'((fc0 + grants) % 65536));

    // frame_count wrap from 0xFFFF
    @(negedge clk);
    force dut.frame_count_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.frame_count_q;
    @(negedge clk);
    chk("wrap_preload", 32'(frame_count), 32'hFFFF);
    run_frame(4'b1000, 32'h3C00_0000, 1'b0, a, n, d, lg, st, cyc, stable, starts);
    chk("wrap_tx_data", 32'(d), 32'h3C);
    chk("wrap_frame_count", 32'(frame_count), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
